// File: rtl/sram_serial_cmd_ctrl.sv
// Command sequencer in front of the SRAM top: turns parallel read/write commands
// into the serial shift/load/w_en/r_en pin protocol and returns read responses.
module sram_serial_cmd_ctrl #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int RD_TIMEOUT = 16,
    localparam int AW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [COLS-1:0] cmd_wdata,
    output logic            serial_in,
    output logic            shift,
    output logic            load,
    output logic            w_en,
    output logic            r_en,
    output logic [AW-1:0]   addr,
    input  logic            data_valid,
    input  logic [COLS-1:0] data_out,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [COLS-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            wr_done
);

    localparam int CW = $clog2(COLS) + 1;
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(COLS - 1);
    localparam logic [TW-1:0] LAST_WAIT = TW'(RD_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, SHIFT, LOAD, GAP, WRITE, RD_SETUP, READ, RD_WAIT, RESP
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic            w_accept;

    logic            r_cmdReady;
    logic            r_serialIn;
    logic            r_shift;
    logic            r_load;
    logic            r_wEn;
    logic            r_rEn;
    logic [AW-1:0]   r_addr;
    logic            r_rspValid;
    logic [COLS-1:0] r_rspRdata;
    logic            r_rspErr;
    logic            r_wrDone;
    logic [COLS-1:0] r_sreg;
    logic [CW-1:0]   r_bitCnt;
    logic [TW-1:0]   r_waitCnt;

    assign w_accept = (r_state == IDLE) && cmd_valid && r_cmdReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_stateNext = cmd_we ? SHIFT : RD_SETUP;
            SHIFT:    if (r_bitCnt == LAST_BIT) w_stateNext = LOAD;
            LOAD:     w_stateNext = GAP;
            GAP:      w_stateNext = WRITE;
            WRITE:    w_stateNext = IDLE;
            RD_SETUP: w_stateNext = READ;
            READ:     w_stateNext = RD_WAIT;
            RD_WAIT:  if (data_valid || (r_waitCnt == LAST_WAIT)) w_stateNext = RESP;
            RESP:     if (rsp_ready) w_stateNext = IDLE;
            default:  w_stateNext = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so every output lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmdReady <= 1'b1;
            r_serialIn <= 1'b0;
            r_shift    <= 1'b0;
            r_load     <= 1'b0;
            r_wEn      <= 1'b0;
            r_rEn      <= 1'b0;
            r_addr     <= '0;
            r_rspValid <= 1'b0;
            r_rspRdata <= '0;
            r_rspErr   <= 1'b0;
            r_wrDone   <= 1'b0;
            r_sreg     <= '0;
            r_bitCnt   <= '0;
            r_waitCnt  <= '0;
        end else begin
            r_cmdReady <= (w_stateNext == IDLE);
            r_shift    <= (w_stateNext == SHIFT);
            r_load     <= (w_stateNext == LOAD);
            r_wEn      <= (w_stateNext == WRITE);
            r_rEn      <= (w_stateNext == READ);
            r_rspValid <= (w_stateNext == RESP);
            r_wrDone   <= (r_state == WRITE);
            r_serialIn <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr   <= cmd_addr;
                        r_sreg   <= cmd_wdata << 1;
                        r_bitCnt <= '0;
                        if (cmd_we) r_serialIn <= cmd_wdata[COLS-1];
                    end
                end
                SHIFT: begin
                    r_bitCnt <= r_bitCnt + 1'b1;
                    if (w_stateNext == SHIFT) begin
                        r_serialIn <= r_sreg[COLS-1];
                        r_sreg     <= r_sreg << 1;
                    end
                end
                READ: r_waitCnt <= '0;
                RD_WAIT: begin
                    r_waitCnt <= r_waitCnt + 1'b1;
                    if (data_valid) begin
                        r_rspRdata <= data_out;
                        r_rspErr   <= 1'b0;
                    end else if (r_waitCnt == LAST_WAIT) begin
                        r_rspRdata <= '0;
                        r_rspErr   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = r_cmdReady;
    assign serial_in = r_serialIn;
    assign shift     = r_shift;
    assign load      = r_load;
    assign w_en      = r_wEn;
    assign r_en      = r_rEn;
    assign addr      = r_addr;
    assign rsp_valid = r_rspValid;
    assign rsp_rdata = r_rspRdata;
    assign rsp_err   = r_rspErr;
    assign wr_done   = r_wrDone;

endmodule

// File: tb/tb_sram_serial_cmd_ctrl.sv
// Directed bench for sram_serial_cmd_ctrl: write/read sequences, timeout, backpressure,
// mid-shift reset and a full write/read sweep against a serial-protocol SRAM model.
module tb_sram_serial_cmd_ctrl;

    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int RD_TIMEOUT = 16;
    localparam int AW         = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_we = 1'b0;
    logic [AW-1:0]   cmd_addr = '0;
    logic [COLS-1:0] cmd_wdata = '0;
    logic            serial_in;
    logic            shift;
    logic            load;
    logic            w_en;
    logic            r_en;
    logic [AW-1:0]   addr;
    logic            data_valid = 1'b0;
    logic [COLS-1:0] data_out = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [COLS-1:0] rsp_rdata;
    logic            rsp_err;
    logic            wr_done;

    int vectorCount = 0;
    int missCount   = 0;
    int strobeErr   = 0;
    int loadCnt     = 0;
    int wenCnt      = 0;

    logic [COLS-1:0] mSr = '0;
    logic [COLS-1:0] mLatch = '0;
    logic [COLS-1:0] mMem [ROWS];
    logic [COLS-1:0] expMem [ROWS];

    sram_serial_cmd_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .serial_in(serial_in), .shift(shift), .load(load), .w_en(w_en), .r_en(r_en),
        .addr(addr), .data_valid(data_valid), .data_out(data_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .wr_done(wr_done)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM top plus a watch on strobe exclusivity and serial_in idling low.
    always @(posedge clk) begin
        if (!rst) begin
            if ($countones({shift, load, w_en, r_en}) > 1) strobeErr++;
            if (!shift && serial_in) strobeErr++;
            if (shift) mSr = {mSr[COLS-2:0], serial_in};
            if (load) begin
                mLatch = mSr;
                loadCnt++;
            end
            if (w_en) begin
                mMem[addr] = mLatch;
                wenCnt++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for cmd_ready, then presents one command for a single accepting edge.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] a, input logic [COLS-1:0] d);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            step();
            n++;
        end
        if (!cmd_ready) checkOutput("cmdReadyTimeout", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic writeCmd(input logic [AW-1:0] a, input logic [COLS-1:0] d, input bit detail);
        int lowCycles = 0;
        int n = 0;
        applyStimulus(1'b1, a, d);
        expMem[a] = d;
        if (detail) begin
            for (int k = 0; k < COLS; k++) begin
                checkOutput($sformatf("shift%0d", k), {31'd0, shift}, 32'd1);
                checkOutput($sformatf("serialIn%0d", k), {31'd0, serial_in}, {31'd0, d[COLS-1-k]});
                if (!cmd_ready) lowCycles++;
                step();
            end
            checkOutput("loadPulse", {28'd0, shift, load, w_en, r_en}, 32'h4);
            if (!cmd_ready) lowCycles++;
            step();
            checkOutput("gapQuiet", {28'd0, shift, load, w_en, r_en}, 32'h0);
            if (!cmd_ready) lowCycles++;
            step();
            checkOutput("wEnPulse", {28'd0, shift, load, w_en, r_en}, 32'h2);
            checkOutput("wEnAddr", {30'd0, addr}, {30'd0, a});
            if (!cmd_ready) lowCycles++;
            step();
            checkOutput("busyCycles", lowCycles, COLS + 3);
            checkOutput("wrDone", {31'd0, wr_done}, 32'd1);
            checkOutput("readyAfterWrite", {31'd0, cmd_ready}, 32'd1);
            step();
            checkOutput("wrDoneOnce", {31'd0, wr_done}, 32'd0);
        end else begin
            while (!wr_done && n < 50) begin
                step();
                n++;
            end
            checkOutput("wrDoneSweep", {31'd0, wr_done}, 32'd1);
        end
    endtask

    // delay < 0 means the SRAM never answers; strayRen drives a wrong word during the r_en cycle.
    task automatic readCmd(input logic [AW-1:0] a, input int delay, input logic [COLS-1:0] drv,
                           input logic [COLS-1:0] expData, input logic expErr, input int hold,
                           input bit detail, input bit strayRen);
        int sinceRen = 0;
        applyStimulus(1'b0, a, '0);
        if (detail) checkOutput("rdSetupQuiet", {28'd0, shift, load, w_en, r_en}, 32'h0);
        step();
        if (detail) begin
            checkOutput("rEnPulse", {28'd0, shift, load, w_en, r_en}, 32'h1);
            checkOutput("rEnAddr", {30'd0, addr}, {30'd0, a});
        end
        if (strayRen) begin
            data_valid = 1'b1;
            data_out   = ~expData;
        end
        if (delay > 0) begin
            for (int i = 0; i < delay; i++) begin
                step();
                sinceRen++;
                data_valid = 1'b0;
            end
            data_valid = 1'b1;
            data_out   = drv;
            step();
            sinceRen++;
            data_valid = 1'b0;
        end else begin
            step();
            sinceRen++;
            data_valid = 1'b0;
        end
        while (!rsp_valid && sinceRen < RD_TIMEOUT + 5) begin
            step();
            sinceRen++;
        end
        checkOutput("rspValid", {31'd0, rsp_valid}, 32'd1);
        if (detail) checkOutput("rspLatency", sinceRen, (delay > 0) ? delay + 1 : RD_TIMEOUT + 1);
        checkOutput("rspRdata", {28'd0, rsp_rdata}, {28'd0, expData});
        checkOutput("rspErr", {31'd0, rsp_err}, {31'd0, expErr});
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_we    = 1'b1;
            step();
            checkOutput($sformatf("holdValid%0d", i), {31'd0, rsp_valid}, 32'd1);
            checkOutput($sformatf("holdRdata%0d", i), {28'd0, rsp_rdata}, {28'd0, expData});
            checkOutput($sformatf("holdReady%0d", i), {31'd0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checkOutput("rspValidDrop", {31'd0, rsp_valid}, 32'd0);
        checkOutput("readyAfterResp", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int prevLoad;
        int prevWen;
        logic [COLS-1:0] word;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checkOutput("rstCmdReady", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rstStrobes", {28'd0, shift, load, w_en, r_en}, 32'h0);
        checkOutput("rstMisc", {28'd0, serial_in, rsp_valid, rsp_err, wr_done}, 32'h0);
        checkOutput("rstAddrData", {26'd0, addr, rsp_rdata}, 32'h0);

        writeCmd(2'd2, 4'b1011, 1'b1);
        readCmd(2'd3, 2, 4'hA, 4'hA, 1'b0, 5, 1'b1, 1'b0);
        readCmd(2'd1, -1, 4'h0, 4'h0, 1'b1, 0, 1'b1, 1'b0);

        applyStimulus(1'b1, 2'd3, 4'b1111);
        step();
        checkOutput("shiftBeforeReset", {31'd0, shift}, 32'd1);
        prevLoad = loadCnt;
        prevWen  = wenCnt;
        rst = 1'b1;
        step();
        checkOutput("abortShift", {31'd0, shift}, 32'd0);
        checkOutput("abortSerial", {31'd0, serial_in}, 32'd0);
        checkOutput("abortAddr", {30'd0, addr}, 32'd0);
        rst = 1'b0;
        step();
        checkOutput("readyAfterAbort", {31'd0, cmd_ready}, 32'd1);
        repeat (12) step();
        checkOutput("noLoadAfterAbort", loadCnt, prevLoad);
        checkOutput("noWenAfterAbort", wenCnt, prevWen);

        for (int w = 0; w < 16; w++) begin
            for (int r = 0; r < ROWS; r++) begin
                word = 4'((w + r * 5) % 16);
                writeCmd(AW'(r), word, 1'b0);
            end
            for (int r = 0; r < ROWS; r++) begin
                data_valid = 1'b1;
                data_out   = ~expMem[r];
                step();
                data_valid = 1'b0;
                readCmd(AW'(r), 1 + (r % 3), mMem[r], expMem[r], 1'b0, 0, 1'b0, 1'b1);
            end
        end

        checkOutput("strobeExclusive", strobeErr, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
